// File: rtl/swg_output_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | swg_output_stage_if : upstream/downstream handshake bundle of the stage    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface swg_output_stage_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_data;
  logic                         out_last;
  logic [$clog2(DEPTH+1)-1:0]   count;

  // master is the environment around the stage, slave is the stage itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, count
  );
endinterface
`default_nettype wire

// File: rtl/swg_output_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | swg_output_stage : first-word-fall-through FIFO with frame-end marking     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module swg_output_stage #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int FRAME_WORDS = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  swg_output_stage_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FRM_W = $clog2(FRAME_WORDS + 1);

  localparam logic [CNT_W-1:0] c_full       = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);
  localparam logic [FRM_W-1:0] c_frm_one    = FRM_W'(1);
  localparam logic [FRM_W-1:0] c_frame_last = FRM_W'(FRAME_WORDS - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [FRM_W-1:0] r_frame_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_frame_end;

  // Full/empty come only from the stored count, so in_ready never sees out_ready
  assign w_full      = (r_count == c_full);
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.in_valid & ~w_full;
  assign w_pop       = bus.out_ready & ~w_empty;
  assign w_frame_end = (r_frame_cnt == c_frame_last);

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.out_last  = w_frame_end & ~w_empty;
  assign bus.count     = r_count;

  // Storage is not reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (w_push && rst_n) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + c_ptr_one;
        r_frame_cnt <= w_frame_end ? '0 : r_frame_cnt + c_frm_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swg_output_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_swg_output_stage : directed scenarios plus random traffic vs queue model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_swg_output_stage;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 4;
  localparam int FRAME_WORDS = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  swg_output_stage_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  swg_output_stage #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: an ideal queue plus a running count of popped words
  logic [WIDTH-1:0] mq[$];
  int               pop_idx;
  logic [WIDTH-1:0] push_log[$];
  logic [WIDTH-1:0] pop_data[$];
  logic             pop_last[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    check("rst_count_async", bus.count, 0);
    check("rst_valid_async", bus.out_valid, 0);
    check("rst_ready_async", bus.in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Model update on each accepted edge
  initial begin
    bit do_pop, do_push;
    pop_idx = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        push_log.delete();
        pop_data.delete();
        pop_last.delete();
        pop_idx = 0;
      end else begin
        do_pop  = (mq.size() != 0) && bus.out_ready;
        do_push = bus.in_valid && (mq.size() != DEPTH);
        if (do_pop) begin
          void'(mq.pop_front());
          pop_idx++;
        end
        if (do_push) begin
          mq.push_back(bus.in_data);
          push_log.push_back(bus.in_data);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus logging of words about to pop
  initial begin
    int exp_last;
    forever begin
      @(negedge clk);
      exp_last = (mq.size() != 0) && ((pop_idx % FRAME_WORDS) == FRAME_WORDS - 1);
      check("cyc_count",     bus.count,     mq.size());
      check("cyc_out_valid", bus.out_valid, (mq.size() != 0));
      check("cyc_in_ready",  bus.in_ready,  (mq.size() != DEPTH));
      check("cyc_out_last",  bus.out_last,  exp_last);
      if (mq.size() != 0) begin
        check("cyc_out_data", bus.out_data, mq[0]);
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
        pop_data.push_back(bus.out_data);
        pop_last.push_back(bus.out_last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    tick();
    tick();
    check("reset_count", bus.count, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_last", bus.out_last, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Scenario 1: single word, one-cycle latency
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h11;
    tick();
    idle();
    check("s1_out_valid", bus.out_valid, 1);
    check("s1_out_data", bus.out_data, 8'h11);
    check("s1_count", bus.count, 1);
    check("s1_out_last", bus.out_last, 0);

    // Scenario 2: fill, blocked push, pop while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA0 + 8'(i);
      tick();
    end
    check("s2_count_full", bus.count, 4);
    check("s2_in_ready_full", bus.in_ready, 0);
    bus.in_data = 8'hFF;
    tick();
    check("s2_count_blocked", bus.count, 4);
    check("s2_head_blocked", bus.out_data, 8'hA0);
    bus.in_data   = 8'hEE;
    bus.out_ready = 1'b1;
    #3;
    check("s2_in_ready_during_pop", bus.in_ready, 0);
    check("s2_pop_word", bus.out_data, 8'hA0);
    tick();
    idle();
    check("s2_count_after_pop", bus.count, 3);
    check("s2_in_ready_after_pop", bus.in_ready, 1);
    check("s2_new_head", bus.out_data, 8'hA1);

    // Scenario 3: streaming with continuous out_ready
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
      check("s3_count_le1", (bus.count <= 1), 1);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s3_count_le1", (bus.count <= 1), 1);
    end
    check("s3_pops", pop_data.size(), 7);
    for (int i = 0; i < 7 && i < pop_data.size(); i++) begin
      check("s3_data", pop_data[i], i + 1);
      check("s3_last", pop_last[i], (i == 2 || i == 5));
    end

    // Scenario 4: push and pop together at count=2 across pointer wrap
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h40 + 8'(i);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      bus.in_data = 8'h40 + 8'(i);
      tick();
      check("s4_count_steady", bus.count, 2);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("s4_pops", pop_data.size(), 10);
    for (int i = 0; i < 10 && i < pop_data.size(); i++) begin
      check("s4_order", pop_data[i], 8'h40 + i);
    end

    // Scenario 5: reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h51 + 8'(i);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("s5_pre_reset_valid", bus.out_valid, 1);
    check("s5_pre_reset_head", bus.out_data, 8'h53);
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h61 + 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("s5_pops", pop_data.size(), 3);
    for (int i = 0; i < 3 && i < pop_data.size(); i++) begin
      check("s5_data", pop_data[i], 8'h61 + i);
      check("s5_last", pop_last[i], (i == 2));
    end

    // Scenario 6: random traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("s6_drained", bus.count, 0);
    check("s6_pop_total", pop_data.size(), push_log.size());
    for (int i = 0; i < pop_data.size() && i < push_log.size(); i++) begin
      check("s6_order", pop_data[i], push_log[i]);
      check("s6_last", pop_last[i], ((i % FRAME_WORDS) == FRAME_WORDS - 1));
    end

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swg_output_stage.md
SWG_OUTPUT_STAGE -- requirements
Module: swg_output_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning bit width of one output word.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning FIFO capacity in words; it must be a power of two and at least 2.
REQ-003 The module SHALL have parameter FRAME_WORDS, default 9, meaning output words per frame; it must be at least 1.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit: the upstream SWG word is valid.
REQ-008 Port in_ready, output, 1 bit: the stage accepts a word this cycle.
REQ-009 Port in_data, input, WIDTH bits: upstream word.
REQ-010 Port out_valid, output, 1 bit: the head word is available.
REQ-011 Port out_ready, input, 1 bit: the downstream consumer accepts.
REQ-012 Port out_data, output, WIDTH bits: head word.
REQ-013 Port out_last, output, 1 bit: the head word is the final word of a frame.
REQ-014 Port count, output, $clog2(DEPTH+1) bits: number of words currently stored.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both high on a clock edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-016 in_ready SHALL equal (count != DEPTH); it is driven combinationally from registered state and has no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be the oldest stored word (first-word fall-through).
REQ-018 Latency: a word pushed into an empty stage SHALL appear on out_data with out_valid high in the next cycle; there is no same-cycle bypass.
REQ-019 count SHALL increase by 1 on push-only, decrease by 1 on pop-only, and stay unchanged on simultaneous push and pop.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits each, increment by 1 per pop and push respectively, and wrap modulo DEPTH.
REQ-021 When full, in_ready SHALL be low, so a push is not possible even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
REQ-022 When empty, out_valid SHALL be low and out_ready SHALL be ignored; pointers and count are unchanged.
REQ-023 The frame counter SHALL be $clog2(FRAME_WORDS+1) bits, increment on each pop, and wrap to 0 on the pop where it equals FRAME_WORDS-1.
REQ-024 out_last SHALL be (frame counter == FRAME_WORDS-1) AND out_valid; with FRAME_WORDS=1, out_last equals out_valid.
REQ-025 out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-026 Storage SHALL accept any implementation (registers or distributed RAM); out_data must be valid in the same cycle out_valid is high.

Reset
REQ-027 While rst_n is low, the following SHALL be held at 0 asynchronously: count, the pointers, and the frame counter. Consequently out_valid=0, out_last=0, and in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard all stored words and the partial-frame position; the first pop after release is word 0 of a new frame.
REQ-029 Storage contents SHALL NOT be reset; out_data is don't-care while out_valid is low.
REQ-030 Deassertion of rst_n SHALL take effect at the next clk edge, with no push or pop in a cycle where rst_n is low.

Verification (WIDTH=8, DEPTH=4, FRAME_WORDS=3)
REQ-031 Scenario 1: push 0x11 into an empty stage with out_ready=0 -> the next cycle shows out_valid=1, out_data=0x11, count=1, out_last=0.
REQ-032 Scenario 2: push 0xA0..0xA3 with out_ready=0 -> count=4, in_ready=0; a further in_valid causes no change. Then pulse out_ready for one cycle together with in_valid -> out pops 0xA0, count=3, and in_ready=1 on the following cycle.
REQ-033 Scenario 3: stream 7 words (0x01..0x07) with out_ready=1 continuously -> outputs arrive in order; out_last is high on 0x03 and 0x06 only; count is never greater than 1.
REQ-034 Scenario 4: simultaneous push and pop at count=2 -> count stays 2 and order is preserved across pointer wrap (push 10 words total, check FIFO order).
REQ-035 Scenario 5: pop 2 words of a frame, then assert rst_n low asynchronously between edges -> out_valid=0 and count=0 immediately; after release, the next 3 popped words have out_last only on the 3rd.
REQ-036 Scenario 6: random in_valid and out_ready (10k cycles) against a scoreboard -> no loss, duplication, or reordering; out_last is on every 3rd popped word; count matches the model every cycle.
